// File: rtl/ysyx_22041461_mem_arbiter.sv
// Single-port memory arbiter between ICACHE refill and DCACHE miss/write paths.
// Optional YSYX_22041461_ARB_DC_PRIO_EN: DCACHE wins every tie (fixed priority).
module ysyx_22041461_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_wen,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic [MASK_W-1:0] dc_mask,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_wen;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [MASK_W-1:0] r_mem_mask;

    logic w_idle;
    logic w_gnt_ic;
    logic w_gnt_dc;
    logic w_resp;

`ifdef YSYX_22041461_ARB_DC_PRIO_EN
    assign w_gnt_ic = ic_req_valid & ~dc_req_valid;
`else
    // On a tie, IC wins only if DC was served last.
    assign w_gnt_ic = ic_req_valid & (~dc_req_valid | (r_last_grant == OWN_DC));
`endif
    assign w_gnt_dc = dc_req_valid & ~w_gnt_ic;

    // Outputs are gated by rst so nothing is handshaken during reset.
    assign w_idle        = (r_state == S_IDLE) & ~rst;
    assign ic_req_ready  = w_idle & w_gnt_ic;
    assign dc_req_ready  = w_idle & w_gnt_dc;
    assign mem_req_valid = (r_state == S_ISSUE) & ~rst;
    assign w_resp        = (r_state == S_WAIT) & mem_resp_valid & ~rst;
    assign ic_resp_valid = w_resp & (r_owner == OWN_IC);
    assign dc_resp_valid = w_resp & (r_owner == OWN_DC);
    assign ic_rdata      = mem_rdata;
    assign dc_rdata      = mem_rdata;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_mask      = r_mem_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IC;
            r_last_grant <= OWN_DC;
            r_mem_addr   <= '0;
            r_mem_wen    <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_mask   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_ic) begin
                        r_owner      <= OWN_IC;
                        r_last_grant <= OWN_IC;
                        r_mem_addr   <= ic_addr;
                        r_mem_wen    <= 1'b0;
                        r_mem_wdata  <= '0;
                        r_mem_mask   <= '1;
                        r_state      <= S_ISSUE;
                    end else if (w_gnt_dc) begin
                        r_owner      <= OWN_DC;
                        r_last_grant <= OWN_DC;
                        r_mem_addr   <= dc_addr;
                        r_mem_wen    <= dc_wen;
                        r_mem_wdata  <= dc_wdata;
                        r_mem_mask   <= dc_mask;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041461_mem_arbiter.sv
// Random-stimulus bench for ysyx_22041461_mem_arbiter with a
// transaction-level reference model (pending-request queue).
module tb_ysyx_22041461_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_req_valid;
    logic        ic_req_ready;
    logic [63:0] ic_addr;
    logic        ic_resp_valid;
    logic [63:0] ic_rdata;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic [63:0] dc_addr;
    logic        dc_wen;
    logic [63:0] dc_wdata;
    logic [7:0]  dc_mask;
    logic        dc_resp_valid;
    logic [63:0] dc_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    ysyx_22041461_mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req_valid  (ic_req_valid),
        .ic_req_ready  (ic_req_ready),
        .ic_addr       (ic_addr),
        .ic_resp_valid (ic_resp_valid),
        .ic_rdata      (ic_rdata),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_addr       (dc_addr),
        .dc_wen        (dc_wen),
        .dc_wdata      (dc_wdata),
        .dc_mask       (dc_mask),
        .dc_resp_valid (dc_resp_valid),
        .dc_rdata      (dc_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_mask      (mem_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          dc;
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        logic [7:0]  mask;
        bit          sent;
    } txn_t;

    txn_t pend[$];
    bit   m_last_dc;
    int   n_vec;
    int   n_err;
    bit   ic_acc;
    bit   dc_acc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 = nobody, 1 = IC, 2 = DC
    function automatic int winner(input bit icv, input bit dcv);
        if (icv && dcv) begin
`ifdef YSYX_22041461_ARB_DC_PRIO_EN
            return 2;
`else
            return m_last_dc ? 1 : 2;
`endif
        end
        if (icv) return 1;
        if (dcv) return 2;
        return 0;
    endfunction

    initial begin
        int   w;
        bit   busy;
        bit   exp_mreq;
        bit   exp_resp;
        txn_t t;

        n_vec = 0;
        n_err = 0;
        ic_acc = 0;
        dc_acc = 0;
        rst = 1'b1;
        ic_req_valid = 0;
        ic_addr = '0;
        dc_req_valid = 0;
        dc_addr = '0;
        dc_wen = 0;
        dc_wdata = '0;
        dc_mask = '0;
        mem_req_ready = 0;
        mem_resp_valid = 0;
        mem_rdata = '0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_ic_ready", ic_req_ready, 0);
            chk("rst_dc_ready", dc_req_ready, 0);
            chk("rst_mem_valid", mem_req_valid, 0);
            chk("rst_ic_resp", ic_resp_valid, 0);
            chk("rst_dc_resp", dc_resp_valid, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_mask", mem_mask, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("idle_mem_valid", mem_req_valid, 0);

        m_last_dc = 1;
        pend.delete();

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk);
            #1;
            if (ic_acc) ic_req_valid = 0;
            else if (!ic_req_valid && $urandom_range(0, 2) == 0) begin
                ic_req_valid = 1;
                ic_addr = {$urandom, $urandom};
            end
            if (dc_acc) dc_req_valid = 0;
            else if (!dc_req_valid && $urandom_range(0, 2) == 0) begin
                dc_req_valid = 1;
                dc_addr = {$urandom, $urandom};
                dc_wen = 1'($urandom_range(0, 1));
                dc_wdata = {$urandom, $urandom};
                dc_mask = 8'($urandom);
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
            mem_resp_valid = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom};
            rst = ($urandom_range(0, 199) == 0);

            @(negedge clk);
            busy = (pend.size() != 0);
            w = (busy || rst) ? 0 : winner(ic_req_valid, dc_req_valid);
            exp_mreq = !rst && busy && !pend[0].sent;
            exp_resp = !rst && busy && pend[0].sent && mem_resp_valid;

            chk("ic_req_ready", ic_req_ready, (w == 1));
            chk("dc_req_ready", dc_req_ready, (w == 2));
            chk("mem_req_valid", mem_req_valid, exp_mreq);
            if (exp_mreq) begin
                chk("mem_addr", mem_addr, pend[0].addr);
                chk("mem_wen", mem_wen, pend[0].wen);
                chk("mem_wdata", mem_wdata, pend[0].wdata);
                chk("mem_mask", mem_mask, pend[0].mask);
            end
            chk("ic_resp_valid", ic_resp_valid, exp_resp && !pend[0].dc);
            chk("dc_resp_valid", dc_resp_valid, exp_resp && pend[0].dc);
            chk("ic_rdata", ic_rdata, mem_rdata);
            chk("dc_rdata", dc_rdata, mem_rdata);

            ic_acc = (w == 1);
            dc_acc = (w == 2);
            if (rst) begin
                pend.delete();
                m_last_dc = 1;
            end else begin
                if (exp_resp) void'(pend.pop_front());
                else if (exp_mreq && mem_req_ready) begin
                    t = pend[0];
                    t.sent = 1;
                    pend[0] = t;
                end
                if (w == 1) begin
                    t.dc = 0;
                    t.addr = ic_addr;
                    t.wen = 0;
                    t.wdata = '0;
                    t.mask = 8'hff;
                    t.sent = 0;
                    pend.push_back(t);
                    m_last_dc = 0;
                end else if (w == 2) begin
                    t.dc = 1;
                    t.addr = dc_addr;
                    t.wen = dc_wen;
                    t.wdata = dc_wdata;
                    t.mask = dc_mask;
                    t.sent = 0;
                    pend.push_back(t);
                    m_last_dc = 1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
